// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-subset decode stage: register read, hazards, branch resolution
//
// Purpose:
//   Decodes the fetched instruction, reads rs/rt from the register file,
//   detects read-after-write hazards against EX/MEM/WB, resolves branches and
//   jumps (one delay slot, no squash) and registers operands/control for EX.
//
// Optional feature macro: DE_FORWARD_EN
//   defined   - operands bypassed EX > MEM > WB > register file; stall only on
//               a load-use dependency against EX.
//   undefined - no bypass; stall while any source matches any in-flight dest.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   fe_pc, fe_inst              instruction being decoded
//   rf_raddr1/2, rf_rdata1/2    register file read port (rs / rt)
//   ex/mem/wb_dest, ex_is_load  in-flight destinations (0 = none)
//   ex/mem/wb_result            bypass values
//   stall                       freeze fetch and PC this cycle
//   br_taken, br_target         PC redirect
//   de_*                        registered decode results for execute

module decode_stage #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fe_pc,
    input  logic [31:0] fe_inst,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic [4:0]  ex_dest,
    input  logic [4:0]  mem_dest,
    input  logic [4:0]  wb_dest,
    input  logic        ex_is_load,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic        stall,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        de_valid,
    output logic [31:0] de_pc,
    output logic [31:0] de_inst,
    output logic [3:0]  de_alu_op,
    output logic [31:0] de_vsrc1,
    output logic [31:0] de_vsrc2,
    output logic [31:0] de_store_data,
    output logic        de_mem_re,
    output logic        de_mem_we,
    output logic [4:0]  de_dest
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] jidx;

    assign opcode = fe_inst[31:26];
    assign rs     = fe_inst[25:21];
    assign rt     = fe_inst[20:16];
    assign rd     = fe_inst[15:11];
    assign sa     = fe_inst[10:6];
    assign funct  = fe_inst[5:0];
    assign imm    = fe_inst[15:0];
    assign jidx   = fe_inst[25:0];

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    logic [31:0] imm_sext;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign pc_plus4 = fe_pc + 32'd4;
    assign pc_plus8 = fe_pc + 32'd8;

    // Instruction classification. The all-zero word is treated as a plain
    // no-op rather than SLL so that it never occupies the shifter encoding.
    logic       is_alu_r;
    logic       is_shift;
    logic       is_jr;
    logic       is_addiu;
    logic       is_lui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic [3:0] r_alu_op;

    always_comb begin
        is_alu_r = 1'b0;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        is_addiu = 1'b0;
        is_lui   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        r_alu_op = ALU_ADD;
        if (fe_inst != 32'd0) begin
            case (opcode)
                OP_SPECIAL: begin
                    case (funct)
                        FN_ADDU: begin is_alu_r = 1'b1; r_alu_op = ALU_ADD;  end
                        FN_SUBU: begin is_alu_r = 1'b1; r_alu_op = ALU_SUB;  end
                        FN_SLT:  begin is_alu_r = 1'b1; r_alu_op = ALU_SLT;  end
                        FN_SLTU: begin is_alu_r = 1'b1; r_alu_op = ALU_SLTU; end
                        FN_AND:  begin is_alu_r = 1'b1; r_alu_op = ALU_AND;  end
                        FN_OR:   begin is_alu_r = 1'b1; r_alu_op = ALU_OR;   end
                        FN_XOR:  begin is_alu_r = 1'b1; r_alu_op = ALU_XOR;  end
                        FN_NOR:  begin is_alu_r = 1'b1; r_alu_op = ALU_NOR;  end
                        FN_SLL:  begin is_shift = 1'b1; r_alu_op = ALU_SLL;  end
                        FN_SRL:  begin is_shift = 1'b1; r_alu_op = ALU_SRL;  end
                        FN_SRA:  begin is_shift = 1'b1; r_alu_op = ALU_SRA;  end
                        FN_JR:   is_jr = 1'b1;
                        default: ;
                    endcase
                end
                OP_J:     is_j     = 1'b1;
                OP_JAL:   is_jal   = 1'b1;
                OP_BEQ:   is_beq   = 1'b1;
                OP_BNE:   is_bne   = 1'b1;
                OP_ADDIU: is_addiu = 1'b1;
                OP_LUI:   is_lui   = 1'b1;
                OP_LW:    is_lw    = 1'b1;
                OP_SW:    is_sw    = 1'b1;
                default:  ;
            endcase
        end
    end

    // Only registers the instruction actually reads can cause a hazard.
    logic use_rs;
    logic use_rt;

    assign use_rs = is_alu_r | is_jr | is_addiu | is_lw | is_sw | is_beq | is_bne;
    assign use_rt = is_alu_r | is_shift | is_sw | is_beq | is_bne;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    logic [31:0] rs_val;
    logic [31:0] rt_val;

`ifdef DE_FORWARD_EN
    // Later assignments override earlier ones, giving EX > MEM > WB priority.
    always_comb begin
        rs_val = rf_rdata1;
        if (reg_match(rs, wb_dest))  rs_val = wb_result;
        if (reg_match(rs, mem_dest)) rs_val = mem_result;
        if (reg_match(rs, ex_dest))  rs_val = ex_result;
        rt_val = rf_rdata2;
        if (reg_match(rt, wb_dest))  rt_val = wb_result;
        if (reg_match(rt, mem_dest)) rt_val = mem_result;
        if (reg_match(rt, ex_dest))  rt_val = ex_result;
    end

    // A load in EX has no value yet; everything else can be bypassed.
    assign stall = ex_is_load & ((use_rs & reg_match(rs, ex_dest)) |
                                 (use_rt & reg_match(rt, ex_dest)));
`else
    assign rs_val = rf_rdata1;
    assign rt_val = rf_rdata2;

    assign stall = (use_rs & (reg_match(rs, ex_dest) | reg_match(rs, mem_dest) |
                              reg_match(rs, wb_dest))) |
                   (use_rt & (reg_match(rt, ex_dest) | reg_match(rt, mem_dest) |
                              reg_match(rt, wb_dest)));

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_result, mem_result, wb_result};
`endif

    logic br_cond;

    always_comb begin
        br_cond   = 1'b0;
        br_target = 32'd0;
        if (is_beq | is_bne) begin
            br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
            br_cond   = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
        end else if (is_j | is_jal) begin
            br_target = {pc_plus4[31:28], jidx, 2'b00};
            br_cond   = 1'b1;
        end else if (is_jr) begin
            br_target = rs_val;
            br_cond   = 1'b1;
        end
    end

    // Operands may be stale while stalled; the branch is re-evaluated once
    // the hazard clears, so no redirect is issued in the meantime.
    assign br_taken = br_cond & ~stall;

    logic [3:0]  d_alu_op;
    logic [31:0] d_vsrc1;
    logic [31:0] d_vsrc2;
    logic [31:0] d_store;
    logic        d_re;
    logic        d_we;
    logic [4:0]  d_dest;

    always_comb begin
        d_alu_op = ALU_ADD;
        d_vsrc1  = 32'd0;
        d_vsrc2  = 32'd0;
        d_store  = 32'd0;
        d_re     = 1'b0;
        d_we     = 1'b0;
        d_dest   = 5'd0;
        if (is_alu_r) begin
            d_alu_op = r_alu_op;
            d_vsrc1  = rs_val;
            d_vsrc2  = rt_val;
            d_dest   = rd;
        end else if (is_shift) begin
            d_alu_op = r_alu_op;
            d_vsrc1  = {27'd0, sa};
            d_vsrc2  = rt_val;
            d_dest   = rd;
        end else if (is_addiu | is_lw | is_sw) begin
            d_vsrc1 = rs_val;
            d_vsrc2 = imm_sext;
            d_re    = is_lw;
            d_we    = is_sw;
            d_store = is_sw ? rt_val : 32'd0;
            d_dest  = is_sw ? 5'd0 : rt;
        end else if (is_lui) begin
            d_alu_op = ALU_LUI;
            d_vsrc2  = {16'd0, imm};
            d_dest   = rt;
        end else if (is_jal) begin
            // Link value is computed by the ALU as (pc+8) + 0.
            d_vsrc1 = pc_plus8;
            d_dest  = RA_REG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            // Reset and stall bubble both leave an empty, all-zero slot.
            de_valid      <= 1'b0;
            de_pc         <= 32'd0;
            de_inst       <= 32'd0;
            de_alu_op     <= ALU_ADD;
            de_vsrc1      <= 32'd0;
            de_vsrc2      <= 32'd0;
            de_store_data <= 32'd0;
            de_mem_re     <= 1'b0;
            de_mem_we     <= 1'b0;
            de_dest       <= 5'd0;
        end else begin
            de_valid      <= 1'b1;
            de_pc         <= fe_pc;
            de_inst       <= fe_inst;
            de_alu_op     <= d_alu_op;
            de_vsrc1      <= d_vsrc1;
            de_vsrc2      <= d_vsrc2;
            de_store_data <= d_store;
            de_mem_re     <= d_re;
            de_mem_we     <= d_we;
            de_dest       <= d_dest;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fe_pc;
    logic [31:0] fe_inst;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  ex_dest;
    logic [4:0]  mem_dest;
    logic [4:0]  wb_dest;
    logic        ex_is_load;
    logic [31:0] ex_result;
    logic [31:0] mem_result;
    logic [31:0] wb_result;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        de_valid;
    logic [31:0] de_pc;
    logic [31:0] de_inst;
    logic [3:0]  de_alu_op;
    logic [31:0] de_vsrc1;
    logic [31:0] de_vsrc2;
    logic [31:0] de_store_data;
    logic        de_mem_re;
    logic        de_mem_we;
    logic [4:0]  de_dest;

    logic [31:0] regs [32];

    // Register file model addressed straight from the instruction fields.
    assign rf_rdata1 = regs[fe_inst[25:21]];
    assign rf_rdata2 = regs[fe_inst[20:16]];

    decode_stage dut (
        .clk(clk), .reset(reset), .fe_pc(fe_pc), .fe_inst(fe_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_result(mem_result), .wb_result(wb_result),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .de_valid(de_valid), .de_pc(de_pc), .de_inst(de_inst),
        .de_alu_op(de_alu_op), .de_vsrc1(de_vsrc1), .de_vsrc2(de_vsrc2),
        .de_store_data(de_store_data), .de_mem_re(de_mem_re),
        .de_mem_we(de_mem_we), .de_dest(de_dest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Mnemonics ADDU..LUI are listed in ALU-op order so the op code is the index.
    typedef enum int {
        M_ADDU = 0, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
        M_SLL, M_SRL, M_SRA, M_LUI,
        M_NOP, M_JR, M_ADDIU, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL
    } mn_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] sd;
        logic        re;
        logic        we;
        logic [4:0]  dest;
    } de_t;

    function automatic mn_t classify(input logic [31:0] i);
        if (i == 32'd0) return M_NOP;
        case (i[31:26])
            6'h00: begin
                case (i[5:0])
                    6'h21: return M_ADDU;
                    6'h23: return M_SUBU;
                    6'h2A: return M_SLT;
                    6'h2B: return M_SLTU;
                    6'h24: return M_AND;
                    6'h25: return M_OR;
                    6'h26: return M_XOR;
                    6'h27: return M_NOR;
                    6'h00: return M_SLL;
                    6'h02: return M_SRL;
                    6'h03: return M_SRA;
                    6'h08: return M_JR;
                    default: return M_NOP;
                endcase
            end
            6'h02: return M_J;
            6'h03: return M_JAL;
            6'h04: return M_BEQ;
            6'h05: return M_BNE;
            6'h09: return M_ADDIU;
            6'h0F: return M_LUI;
            6'h23: return M_LW;
            6'h2B: return M_SW;
            default: return M_NOP;
        endcase
    endfunction

    // Architectural value of register r as seen by the decoding instruction.
    function automatic logic [31:0] operand(input logic [4:0] r);
        logic [4:0]  pd [3];
        logic [31:0] pv [3];
        pd = '{ex_dest, mem_dest, wb_dest};
        pv = '{ex_result, mem_result, wb_result};
        if (r == 5'd0) return 32'd0;
`ifdef DE_FORWARD_EN
        for (int k = 0; k < 3; k++)
            if (pd[k] == r) return pv[k];
`endif
        return regs[r];
    endfunction

    function automatic logic blocked(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef DE_FORWARD_EN
        return ex_is_load && (ex_dest == r);
`else
        return (ex_dest == r) || (mem_dest == r) || (wb_dest == r);
`endif
    endfunction

    task automatic predict(output logic st, output logic tk, output logic [31:0] tg, output de_t d);
        mn_t         m;
        logic        rd_rs;
        logic        rd_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] se;
        logic [31:0] p4;
        m  = classify(fe_inst);
        rs = fe_inst[25:21];
        rt = fe_inst[20:16];
        rd_rs = m inside {M_ADDU, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
                          M_JR, M_ADDIU, M_LW, M_SW, M_BEQ, M_BNE};
        rd_rt = m inside {M_ADDU, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
                          M_SLL, M_SRL, M_SRA, M_SW, M_BEQ, M_BNE};
        a  = operand(rs);
        b  = operand(rt);
        se = int'(shortint'(fe_inst[15:0]));
        p4 = fe_pc + 32'd4;
        st = (rd_rs && blocked(rs)) || (rd_rt && blocked(rt));
        tk = 1'b0;
        tg = 32'd0;
        d  = '{default: '0};
        d.valid = 1'b1;
        d.pc    = fe_pc;
        d.inst  = fe_inst;
        case (m)
            M_ADDU, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR: begin
                d.op = 4'(int'(m)); d.v1 = a; d.v2 = b; d.dest = fe_inst[15:11];
            end
            M_SLL, M_SRL, M_SRA: begin
                d.op = 4'(int'(m)); d.v1 = 32'(fe_inst[10:6]); d.v2 = b; d.dest = fe_inst[15:11];
            end
            M_LUI:   begin d.op = 4'd11; d.v2 = 32'(fe_inst[15:0]); d.dest = rt; end
            M_ADDIU: begin d.v1 = a; d.v2 = se; d.dest = rt; end
            M_LW:    begin d.v1 = a; d.v2 = se; d.dest = rt; d.re = 1'b1; end
            M_SW:    begin d.v1 = a; d.v2 = se; d.sd = b; d.we = 1'b1; end
            M_BEQ:   begin tk = (a == b); tg = p4 + se * 32'd4; end
            M_BNE:   begin tk = (a != b); tg = p4 + se * 32'd4; end
            M_J:     begin tk = 1'b1; tg = (p4 & 32'hF000_0000) | ({6'd0, fe_inst[25:0]} * 32'd4); end
            M_JAL: begin
                tk = 1'b1; tg = (p4 & 32'hF000_0000) | ({6'd0, fe_inst[25:0]} * 32'd4);
                d.v1 = fe_pc + 32'd8; d.dest = 5'd31;
            end
            M_JR:    begin tk = 1'b1; tg = a; end
            default: ;
        endcase
        if (st) begin
            tk = 1'b0;
            d  = '{default: '0};
        end
    endtask

    // Inputs are already applied; check combinational outputs mid-cycle,
    // then the registered slot just after the next rising edge.
    task automatic run_cycle(input string tag);
        logic        st;
        logic        tk;
        logic [31:0] tg;
        de_t         d;
        predict(st, tk, tg, d);
        if (reset) d = '{default: '0};
        @(negedge clk);
        check_eq({tag, ".raddr1"}, 32'(rf_raddr1), 32'(fe_inst[25:21]));
        check_eq({tag, ".raddr2"}, 32'(rf_raddr2), 32'(fe_inst[20:16]));
        check_eq({tag, ".stall"}, 32'(stall), 32'(st));
        check_eq({tag, ".br_taken"}, 32'(br_taken), 32'(tk));
        if (tk) check_eq({tag, ".br_target"}, br_target, tg);
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, 32'(de_valid), 32'(d.valid));
        check_eq({tag, ".pc"}, de_pc, d.pc);
        check_eq({tag, ".inst"}, de_inst, d.inst);
        check_eq({tag, ".alu_op"}, 32'(de_alu_op), 32'(d.op));
        check_eq({tag, ".vsrc1"}, de_vsrc1, d.v1);
        check_eq({tag, ".vsrc2"}, de_vsrc2, d.v2);
        check_eq({tag, ".store"}, de_store_data, d.sd);
        check_eq({tag, ".mem_re"}, 32'(de_mem_re), 32'(d.re));
        check_eq({tag, ".mem_we"}, 32'(de_mem_we), 32'(d.we));
        check_eq({tag, ".dest"}, 32'(de_dest), 32'(d.dest));
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 6));
    endfunction

    task automatic rand_inputs();
        logic [5:0]  fn_tab [11];
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        int          k;
        fn_tab = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
        rs  = pick_reg();
        rt  = pick_reg();
        rd  = pick_reg();
        sa  = 5'($urandom);
        imm = 16'($urandom);
        k   = $urandom_range(0, 21);
        if (k < 11) fe_inst = {6'h00, rs, rt, rd, sa, fn_tab[k]};
        else begin
            case (k)
                11: fe_inst = {6'h0F, rs, rt, imm};
                12: fe_inst = {6'h00, rs, 15'd0, 6'h08};
                13: fe_inst = {6'h09, rs, rt, imm};
                14: fe_inst = {6'h23, rs, rt, imm};
                15: fe_inst = {6'h2B, rs, rt, imm};
                16: fe_inst = {6'h04, rs, rt, imm};
                17: fe_inst = {6'h05, rs, rt, imm};
                18: fe_inst = {6'h02, 26'($urandom)};
                19: fe_inst = {6'h03, 26'($urandom)};
                20: fe_inst = 32'd0;
                default: fe_inst = ($urandom_range(0, 1) == 1) ? {6'h00, rs, rt, rd, 5'd0, 6'h20}
                                                               : {6'h3F, 26'($urandom)};
            endcase
        end
        if ($urandom_range(0, 7) == 0) fe_pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        else fe_pc = 32'($urandom) & ~32'h3;
        for (int i = 1; i < 32; i++)
            regs[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : 32'($urandom);
        ex_dest    = ($urandom_range(0, 1) == 1) ? 5'd0 : pick_reg();
        mem_dest   = ($urandom_range(0, 1) == 1) ? 5'd0 : pick_reg();
        wb_dest    = ($urandom_range(0, 1) == 1) ? 5'd0 : pick_reg();
        ex_is_load = 1'($urandom);
        ex_result  = $urandom;
        mem_result = $urandom;
        wb_result  = $urandom;
        reset      = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        reset = 1'b1;
        fe_inst = 32'h2408_0005;
        fe_pc = 32'hBFC0_0000;
        ex_dest = 5'd0; mem_dest = 5'd0; wb_dest = 5'd0; ex_is_load = 1'b0;
        ex_result = 32'd0; mem_result = 32'd0; wb_result = 32'd0;
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        regs[8] = 32'd3;
        regs[9] = 32'd4;

        // Reset held two cycles, then ADDIU $8,$0,5 is captured.
        repeat (2) begin
            run_cycle("rst");
            check_eq("rst.de_valid", 32'(de_valid), 32'd0);
            check_eq("rst.de_dest", 32'(de_dest), 32'd0);
        end
        reset = 1'b0;
        run_cycle("rel");
        check_eq("rel.de_valid", 32'(de_valid), 32'd1);
        check_eq("rel.de_dest", 32'(de_dest), 32'd8);
        check_eq("rel.de_vsrc2", de_vsrc2, 32'd5);
        check_eq("rel.de_alu_op", 32'(de_alu_op), 32'd0);

        // ADDU $10,$8,$9
        fe_inst = 32'h0109_5021;
        run_cycle("addu");
        check_eq("addu.stall", 32'(stall), 32'd0);
        check_eq("addu.vsrc1", de_vsrc1, 32'd3);
        check_eq("addu.vsrc2", de_vsrc2, 32'd4);
        check_eq("addu.dest", 32'(de_dest), 32'd10);

        // BEQ $1,$2,+4 equal then unequal
        fe_inst = 32'h1022_0004; fe_pc = 32'hBFC0_0010;
        regs[1] = 32'd7; regs[2] = 32'd7;
        run_cycle("beq_eq");
        check_eq("beq_eq.taken", 32'(br_taken), 32'd1);
        check_eq("beq_eq.target", br_target, 32'hBFC0_0024);
        regs[2] = 32'd8;
        run_cycle("beq_ne");
        check_eq("beq_ne.taken", 32'(br_taken), 32'd0);

        // JAL 0x0100000
        fe_inst = 32'h0C10_0000; fe_pc = 32'hBFC0_0000;
        run_cycle("jal");
        check_eq("jal.target", br_target, 32'hB040_0000);
        check_eq("jal.dest", 32'(de_dest), 32'd31);
        check_eq("jal.vsrc1", de_vsrc1, 32'hBFC0_0008);

        // Load-use on $8 for ADDU $10,$8,$0
        fe_inst = 32'h0100_5021;
        ex_dest = 5'd8; ex_is_load = 1'b1;
        run_cycle("ld_use");
        check_eq("ld_use.stall", 32'(stall), 32'd1);
        check_eq("ld_use.valid", 32'(de_valid), 32'd0);
`ifdef DE_FORWARD_EN
        ex_is_load = 1'b0; ex_result = 32'h55;
        run_cycle("fwd_ex");
        check_eq("fwd_ex.stall", 32'(stall), 32'd0);
        check_eq("fwd_ex.vsrc1", de_vsrc1, 32'h55);
        ex_dest = 5'd0;
`else
        ex_dest = 5'd0; ex_is_load = 1'b0; mem_dest = 5'd8;
        run_cycle("haz_mem");
        check_eq("haz_mem.stall", 32'(stall), 32'd1);
        mem_dest = 5'd0; wb_dest = 5'd8;
        run_cycle("haz_wb");
        check_eq("haz_wb.stall", 32'(stall), 32'd1);
        wb_dest = 5'd0;
        run_cycle("haz_clr");
        check_eq("haz_clr.stall", 32'(stall), 32'd0);
        check_eq("haz_clr.vsrc1", de_vsrc1, 32'd3);
`endif

        // JR $31 behind a MEM-stage writer of $31
        fe_inst = 32'h03E0_0008;
        regs[31] = 32'h1234_5678; mem_dest = 5'd31; mem_result = 32'hCAFE_0000;
        run_cycle("jr_haz");
`ifdef DE_FORWARD_EN
        check_eq("jr_haz.stall", 32'(stall), 32'd0);
        check_eq("jr_haz.target", br_target, 32'hCAFE_0000);
`else
        check_eq("jr_haz.stall", 32'(stall), 32'd1);
        check_eq("jr_haz.taken", 32'(br_taken), 32'd0);
`endif
        mem_dest = 5'd0;
        run_cycle("jr_go");
        check_eq("jr_go.taken", 32'(br_taken), 32'd1);
        check_eq("jr_go.target", br_target, 32'h1234_5678);

        // Reset asserted while a hazard stalls decode
        ex_dest = 5'd31; reset = 1'b1;
        run_cycle("rst_stall");
        check_eq("rst_stall.valid", 32'(de_valid), 32'd0);
        reset = 1'b0; ex_dest = 5'd0;

        for (int it = 0; it < 400; it++) begin
            rand_inputs();
            run_cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
